execute_hazard_scheduler: RTL and testbench
===========================================

Name: execute_hazard_scheduler

Overview:
- Sequences the Execute stage of the five-stage pipeline.
- Drives the ForwardAE/ForwardBE operand-select muxes and the stall/flush controls for the F/D/E pipeline registers.
- Owns a small FSM that holds a multi-cycle ALU operation (MUL/DIV class) in Execute for MC_LATENCY cycles while injecting bubbles into Memory.
- Replaces the stub hazard signalling currently tied off at the Execute stage.

Parameters:
MC_LATENCY, 4, total cycles a multi-cycle op occupies Execute (legal range 2..15)
CNT_W, 4, width of the internal occupancy counter (must satisfy 2^CNT_W > MC_LATENCY)

Ports:
clk  in  1  pipeline clock, rising edge
rst_n  in  1  asynchronous active-low reset
Rs1D, Rs2D  in  5 each  source registers of the instruction in Decode
Rs1E, Rs2E, RdE  in  5 each  sources and destination of the instruction in Execute
ResultSrcE  in  2  result select of the instruction in Execute (2'b01 = load)
MultiCycleE  in  1  instruction in Execute is a multi-cycle ALU op
PCSrcE  in  1  taken branch/jump resolved in Execute
RdM, RdW  in  5 each  destinations in Memory and Writeback
RegWriteM, RegWriteW  in  1 each  register-write enables in Memory and Writeback
ForwardAE, ForwardBE  out  2 each  00 = RD1E/RD2E, 01 = ResultW, 10 = ALUResultM; 11 never driven
StallF, StallD, StallE  out  1 each  hold the PC, IF/ID and ID/EX registers
FlushD, FlushE  out  1 each  clear the IF/ID and ID/EX registers to NOP
BubbleM  out  1  clear the EX/MEM register to NOP (RegWriteM = MemWriteM = 0)
McBusy  out  1  registered; multi-cycle op in progress
McDoneE  out  1  registered; final cycle of a multi-cycle op, ALUResultE valid

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst_n` is asynchronous and active-low.
- Reset (async, rst_n=0):
  - state=IDLE, counter=0, McBusy=0, McDoneE=0.
  - Combinational outputs follow the rules below with state=IDLE.
  - Reset mid-operation abandons the op immediately; no McDoneE is produced.
- Forwarding (combinational, shown for A; B is identical with Rs2E):
  - 10 if RegWriteM && RdM!=0 && RdM==Rs1E.
  - Else 01 if RegWriteW && RdW!=0 && RdW==Rs1E.
  - Else 00.
  - Memory has priority over Writeback. x0 is never forwarded.
- Load-use: lwStall = (ResultSrcE==2'b01) && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
- Multi-cycle FSM, states IDLE, BUSY, DONE:
  - IDLE: if MultiCycleE && !PCSrcE, mcStall=1 this cycle and counter<=1. Next state is DONE if MC_LATENCY==2, else BUSY.
  - BUSY: mcStall=1. If counter==MC_LATENCY-2, next state is DONE; else counter<=counter+1.
  - DONE: mcStall=0. Next state is IDLE unconditionally, even though MultiCycleE is still high this cycle, so the op never restarts.
  - Back-to-back multi-cycle ops start from IDLE on the following cycle.
  - The op therefore occupies Execute for exactly MC_LATENCY cycles: MC_LATENCY-1 stall cycles plus one DONE cycle.
  - McBusy=1 in BUSY and DONE. McDoneE=1 only in DONE. Both are decoded from registered state.
- Output equations:
  - StallF = StallD = lwStall | mcStall
  - StallE = BubbleM = mcStall
  - FlushD = PCSrcE
  - FlushE = PCSrcE | (lwStall & !mcStall)
- Simultaneous events:
  - PCSrcE and MultiCycleE come from the same Execute instruction, so both high is illegal. The bench asserts against it; the RTL lets PCSrcE win and does not start the FSM.
  - lwStall with PCSrcE: both flushes apply, so FlushE=1 and StallD=1. The flushed Decode instruction is discarded either way.
  - Forwarding remains active during mcStall. BubbleM keeps RegWriteM=0, so no stale forward from Memory occurs.
- Latency: forwarding, stall and flush outputs are zero-latency combinational from the inputs and current state. The FSM advances on the clk rising edge.

Test Plan:
- Forwarding priority: RdM=RdW=Rs1E=5, RegWriteM=RegWriteW=1 -> ForwardAE=10. Drop RegWriteM -> 01. Set Rs1E=0 with RdM=0 -> 00.
- Load-use: ResultSrcE=01, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1, StallE=0. Set RdE=0 -> all 0.
- Branch flush: PCSrcE=1 for one cycle -> FlushD=FlushE=1 that cycle only, no stalls, FSM stays IDLE.
- Multi-cycle, MC_LATENCY=4: MultiCycleE=1 held -> StallF/StallD/StallE/BubbleM=1 for 3 cycles, McDoneE=1 on cycle 4, state IDLE on cycle 5. Two consecutive ops -> 8 total cycles, exactly two McDoneE pulses.
- Reset mid-op: drop rst_n asynchronously while in BUSY -> McBusy=0 and StallE=0 immediately once MultiCycleE=0. No McDoneE after release.
- MC_LATENCY=2 build: single MultiCycleE op -> exactly 1 stall cycle, then McDoneE=1 for 1 cycle.

Source files
------------

// File: rtl/execute_hazard_scheduler.sv
// Execute-stage hazard control: operand forwarding, load-use and branch stall/flush,
// and a small FSM that holds a multi-cycle ALU op in Execute for MC_LATENCY cycles.
module execute_hazard_scheduler #(
   parameter int MC_LATENCY = 4,
   parameter int CNT_W      = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:0] Rs1D,
   input  logic [4:0] Rs2D,
   input  logic [4:0] Rs1E,
   input  logic [4:0] Rs2E,
   input  logic [4:0] RdE,
   input  logic [1:0] ResultSrcE,
   input  logic       MultiCycleE,
   input  logic       PCSrcE,
   input  logic [4:0] RdM,
   input  logic [4:0] RdW,
   input  logic       RegWriteM,
   input  logic       RegWriteW,
   output logic [1:0] ForwardAE,
   output logic [1:0] ForwardBE,
   output logic       StallF,
   output logic       StallD,
   output logic       StallE,
   output logic       FlushD,
   output logic       FlushE,
   output logic       BubbleM,
   output logic       McBusy,
   output logic       McDoneE,
   output logic [1:0] McStateDbg
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } mc_state_t;

   localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(MC_LATENCY - 2);
   localparam mc_state_t        START_NXT = (MC_LATENCY == 2) ? S_DONE : S_BUSY;

   mc_state_t        r_state;
   mc_state_t        w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_mc_stall;
   logic             w_lw_stall;

   // Memory result is newer than Writeback, so it wins; x0 is hard-wired zero.
   function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
      if (RegWriteM && (RdM != 5'd0) && (RdM == rs))
         fwd_sel = 2'b10;
      else if (RegWriteW && (RdW != 5'd0) && (RdW == rs))
         fwd_sel = 2'b01;
      else
         fwd_sel = 2'b00;
   endfunction

   assign ForwardAE = fwd_sel(Rs1E);
   assign ForwardBE = fwd_sel(Rs2E);

   assign w_lw_stall = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                       ((RdE == Rs1D) || (RdE == Rs2D));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // DONE always returns to IDLE so a still-asserted MultiCycleE cannot retrigger the same op.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_mc_stall  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (MultiCycleE && !PCSrcE) begin
               w_mc_stall  = 1'b1;
               w_cnt_nxt   = CNT_W'(1);
               w_state_nxt = START_NXT;
            end
         end
         S_BUSY: begin
            w_mc_stall = 1'b1;
            if (r_cnt == LAST_CNT)
               w_state_nxt = S_DONE;
            else
               w_cnt_nxt = r_cnt + 1'b1;
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign StallF     = w_lw_stall | w_mc_stall;
   assign StallD     = w_lw_stall | w_mc_stall;
   assign StallE     = w_mc_stall;
   assign BubbleM    = w_mc_stall;
   assign FlushD     = PCSrcE;
   assign FlushE     = PCSrcE | (w_lw_stall & ~w_mc_stall);
   assign McBusy     = (r_state == S_BUSY) || (r_state == S_DONE);
   assign McDoneE    = (r_state == S_DONE);
   assign McStateDbg = r_state;

endmodule

// File: tb/tb_execute_hazard_scheduler.sv
// Bench for execute_hazard_scheduler: a latency-4 and a latency-2 instance share stimulus
// and are compared each negedge against an op-position model, plus literal checks.
module tb_execute_hazard_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0] ResultSrcE;
  logic       MultiCycleE, PCSrcE, RegWriteM, RegWriteW;

  logic [1:0] fa4, fb4, st4, fa2, fb2, st2;
  logic       sf4, sd4, se4, fd4, fe4, bm4, busy4, done4;
  logic       sf2, sd2, se2, fd2, fe2, bm2, busy2, done2;

  int checks = 0;
  int errors = 0;
  int m_pos[2];
  int m_nxt[2];
  int n_done4, n_stall4, n_done2;

  always #5 clk = ~clk;

  execute_hazard_scheduler #(.MC_LATENCY(4), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .ResultSrcE(ResultSrcE), .MultiCycleE(MultiCycleE), .PCSrcE(PCSrcE),
    .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ForwardAE(fa4), .ForwardBE(fb4), .StallF(sf4), .StallD(sd4), .StallE(se4),
    .FlushD(fd4), .FlushE(fe4), .BubbleM(bm4), .McBusy(busy4), .McDoneE(done4),
    .McStateDbg(st4));

  execute_hazard_scheduler #(.MC_LATENCY(2), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .ResultSrcE(ResultSrcE), .MultiCycleE(MultiCycleE), .PCSrcE(PCSrcE),
    .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ForwardAE(fa2), .ForwardBE(fb2), .StallF(sf2), .StallD(sd2), .StallE(se2),
    .FlushD(fd2), .FlushE(fe2), .BubbleM(bm2), .McBusy(busy2), .McDoneE(done2),
    .McStateDbg(st2));

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] model_fwd(input logic [4:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  // pos = which cycle (1..lat) of a multi-cycle op Execute is in this cycle; 0 = none
  task automatic cmp_dut(input int k, input int lat, input string tag,
                         input logic [1:0] fa, input logic [1:0] fb,
                         input logic sf, input logic sd, input logic se,
                         input logic fd, input logic fe, input logic bm,
                         input logic busy, input logic done);
    int  pos;
    logic mc, lw;
    if (!rst_n) m_pos[k] = 0;
    if (m_pos[k] > 0) pos = m_pos[k];
    else if (MultiCycleE && !PCSrcE) pos = 1;
    else pos = 0;
    mc = (pos >= 1) && (pos < lat);
    lw = (ResultSrcE == 2'b01) && (RdE != 0) && (RdE == Rs1D || RdE == Rs2D);
    chk({tag, "_fwdA"}, 8'(fa), 8'(model_fwd(Rs1E)));
    chk({tag, "_fwdB"}, 8'(fb), 8'(model_fwd(Rs2E)));
    chk({tag, "_stallF"}, 8'(sf), 8'(lw | mc));
    chk({tag, "_stallD"}, 8'(sd), 8'(lw | mc));
    chk({tag, "_stallE"}, 8'(se), 8'(mc));
    chk({tag, "_bubbleM"}, 8'(bm), 8'(mc));
    chk({tag, "_flushD"}, 8'(fd), 8'(PCSrcE));
    chk({tag, "_flushE"}, 8'(fe), 8'(PCSrcE | (lw & !mc)));
    chk({tag, "_mcBusy"}, 8'(busy), 8'(m_pos[k] > 0));
    chk({tag, "_mcDone"}, 8'(done), 8'(pos == lat));
    m_nxt[k] = (pos > 0 && pos < lat) ? pos + 1 : 0;
  endtask

  always @(negedge clk) begin
    if (PCSrcE && MultiCycleE) begin
      errors++;
      $display("FAIL illegal_stim: PCSrcE and MultiCycleE both high at %0t", $time);
    end
    cmp_dut(0, 4, "L4", fa4, fb4, sf4, sd4, se4, fd4, fe4, bm4, busy4, done4);
    cmp_dut(1, 2, "L2", fa2, fb2, sf2, sd2, se2, fd2, fe2, bm2, busy2, done2);
    if (done4) n_done4++;
    if (se4) n_stall4++;
    if (done2) n_done2++;
  end

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) m_pos[k] = rst_n ? m_nxt[k] : 0;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    ResultSrcE = 2'b00; MultiCycleE = 0; PCSrcE = 0; RegWriteM = 0; RegWriteW = 0;
  endtask

  initial begin
    m_pos = '{0, 0};
    m_nxt = '{0, 0};
    n_done4 = 0; n_stall4 = 0; n_done2 = 0;
    clear_inputs();
    rst_n = 1'b0;
    #2;
    chk("rst_busy4", 8'(busy4), 8'd0);
    chk("rst_done4", 8'(done4), 8'd0);
    chk("rst_state4", 8'(st4), 8'd0);
    chk("rst_done2", 8'(done2), 8'd0);
    step(); step();
    rst_n = 1'b1;

    // Forwarding priority
    step();
    RdM = 5; RdW = 5; Rs1E = 5; Rs2E = 5; RegWriteM = 1; RegWriteW = 1;
    #1 chk("lit_fwdA_mem", 8'(fa4), 8'h2);
    chk("lit_fwdB_mem", 8'(fb4), 8'h2);
    step();
    RegWriteM = 0;
    #1 chk("lit_fwdA_wb", 8'(fa4), 8'h1);
    step();
    Rs1E = 0; RdM = 0; RegWriteM = 1;
    #1 chk("lit_fwdA_x0", 8'(fa4), 8'h0);
    chk("lit_fwdB_wb", 8'(fb4), 8'h1);
    step();
    RdW = 0; Rs1E = 0; Rs2E = 0;
    #1 chk("lit_fwdB_x0", 8'(fb4), 8'h0);

    // Directed B-side / A-side vectors: {RdM, RdW, RegWriteM, RegWriteW, Rs1E, Rs2E}
    for (int i = 0; i < 6; i++) begin
      step();
      case (i)
        0: begin RdM = 3; RdW = 4; RegWriteM = 1; RegWriteW = 1; Rs1E = 4; Rs2E = 3; end
        1: begin RdM = 3; RdW = 3; RegWriteM = 0; RegWriteW = 1; Rs1E = 3; Rs2E = 9; end
        2: begin RdM = 31; RdW = 31; RegWriteM = 1; RegWriteW = 0; Rs1E = 31; Rs2E = 31; end
        3: begin RdM = 0; RdW = 0; RegWriteM = 1; RegWriteW = 1; Rs1E = 0; Rs2E = 0; end
        4: begin RdM = 8; RdW = 8; RegWriteM = 0; RegWriteW = 0; Rs1E = 8; Rs2E = 8; end
        default: begin RdM = 12; RdW = 13; RegWriteM = 1; RegWriteW = 1; Rs1E = 13; Rs2E = 12; end
      endcase
    end
    step();
    clear_inputs();

    // Load-use
    step();
    ResultSrcE = 2'b01; RdE = 7; Rs2D = 7;
    #1 chk("lit_lw_stallF", 8'(sf4), 8'd1);
    chk("lit_lw_stallD", 8'(sd4), 8'd1);
    chk("lit_lw_flushE", 8'(fe4), 8'd1);
    chk("lit_lw_stallE", 8'(se4), 8'd0);
    step();
    RdE = 0;
    #1 chk("lit_lw_x0_stallD", 8'(sd4), 8'd0);
    chk("lit_lw_x0_flushE", 8'(fe4), 8'd0);

    // Load-use together with a taken branch
    step();
    RdE = 7; Rs1D = 7; Rs2D = 0; PCSrcE = 1;
    #1 chk("lit_lwbr_flushE", 8'(fe4), 8'd1);
    chk("lit_lwbr_stallD", 8'(sd4), 8'd1);
    chk("lit_lwbr_flushD", 8'(fd4), 8'd1);
    step();
    clear_inputs();

    // Branch flush: one cycle only, FSM untouched
    step();
    PCSrcE = 1;
    #1 chk("lit_br_flushD", 8'(fd4), 8'd1);
    chk("lit_br_flushE", 8'(fe4), 8'd1);
    chk("lit_br_stallF", 8'(sf4), 8'd0);
    step();
    PCSrcE = 0;
    #1 chk("lit_br_after_flushD", 8'(fd4), 8'd0);
    chk("lit_br_state", 8'(st4), 8'd0);

    // Single multi-cycle op
    step();
    MultiCycleE = 1;
    #1 chk("lit_mc_c1_stallE", 8'(se4), 8'd1);
    chk("lit_mc_c1_bubbleM", 8'(bm4), 8'd1);
    chk("lit_mc_c1_busy", 8'(busy4), 8'd0);
    chk("lit_mc2_c1_stallE", 8'(se2), 8'd1);
    step();
    #1 chk("lit_mc_c2_stallF", 8'(sf4), 8'd1);
    chk("lit_mc_c2_busy", 8'(busy4), 8'd1);
    chk("lit_mc2_c2_done", 8'(done2), 8'd1);
    chk("lit_mc2_c2_stallE", 8'(se2), 8'd0);
    step();
    #1 chk("lit_mc_c3_stallD", 8'(sd4), 8'd1);
    chk("lit_mc_c3_done", 8'(done4), 8'd0);
    step();
    #1 chk("lit_mc_c4_done", 8'(done4), 8'd1);
    chk("lit_mc_c4_stallE", 8'(se4), 8'd0);
    step();
    MultiCycleE = 0;
    #1 chk("lit_mc_c5_state", 8'(st4), 8'd0);
    chk("lit_mc_c5_busy", 8'(busy4), 8'd0);

    // Back-to-back ops: 8 cycles, two done pulses, forwarding and load-use live meanwhile
    step();
    n_done4 = 0; n_stall4 = 0; n_done2 = 0;
    MultiCycleE = 1; RdM = 6; RegWriteM = 1; Rs1E = 6; RdW = 2; RegWriteW = 1; Rs2E = 2;
    ResultSrcE = 2'b01; RdE = 9; Rs1D = 9;
    for (int i = 0; i < 8; i++) step();
    MultiCycleE = 0;
    clear_inputs();
    step();
    chk("cnt_b2b_done4", 8'(n_done4), 8'd2);
    chk("cnt_b2b_stall4", 8'(n_stall4), 8'd6);
    chk("cnt_b2b_done2", 8'(n_done2), 8'd4);

    // Reset mid-op
    step();
    MultiCycleE = 1;
    step();
    step();
    chk("lit_rst_pre_state", 8'(st4), 8'd1);
    MultiCycleE = 0;
    rst_n = 0;
    #1 chk("lit_rst_busy", 8'(busy4), 8'd0);
    chk("lit_rst_stallE", 8'(se4), 8'd0);
    step();
    rst_n = 1;
    n_done4 = 0; n_done2 = 0;
    for (int i = 0; i < 6; i++) step();
    chk("cnt_rst_no_done4", 8'(n_done4), 8'd0);
    chk("cnt_rst_no_done2", 8'(n_done2), 8'd0);

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
